// File: rtl/oled_pkg.sv
// Shared definitions for the OLED test-pattern generator: mode encodings,
// color-bar palette and an RGB565 packing helper.
package oled_pkg;

  typedef enum logic [1:0] {
    MODE_CHECKER  = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_SCROLL   = 2'd3
  } mode_e;

  localparam int unsigned RGB_W = 16;

  localparam logic [RGB_W-1:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 16'h07FF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 16'h07E0;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [RGB_W-1:0] BAR_RED     = 16'hF800;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 16'h001F;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 16'h0000;

  function automatic logic [RGB_W-1:0] rgb565(input logic [4:0] r,
                                              input logic [5:0] g,
                                              input logic [4:0] b);
    return {r, g, b};
  endfunction

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/oled_pattern_gen_if.sv
// Pixel request / color response bundle between oled_video and the pattern source.
interface oled_pattern_gen_if #(
  parameter int unsigned C_x_bits = 7,
  parameter int unsigned C_y_bits = 8
);
  logic [C_x_bits-1:0] x;
  logic [C_y_bits-1:0] y;
  logic [1:0]          mode;
  logic                pause;
  logic [15:0]         color;
  logic                frame_start;
  logic [7:0]          frame_count;

  modport master (output x, y, mode, pause,
                  input  color, frame_start, frame_count);
  modport slave  (input  x, y, mode, pause,
                  output color, frame_start, frame_count);
endinterface

// File: rtl/oled_frame_tracker.sv
// Detects frame boundaries from the scanned pixel coordinates and keeps the
// frame counter and the scroll offset used for animation.
module oled_frame_tracker #(
  parameter int unsigned C_x_bits     = 7,
  parameter int unsigned C_y_bits     = 8,
  parameter int unsigned C_scroll_div = 2
) (
  input  logic                clki,
  input  logic                resn,
  input  logic [C_x_bits-1:0] x,
  input  logic [C_y_bits-1:0] y,
  input  logic                pause,
  output logic                start_c,
  output logic [C_y_bits-1:0] offset_c,
  output logic                frame_start,
  output logic [7:0]          frame_count
);

  localparam int unsigned XY_W = C_x_bits + C_y_bits;

  logic [XY_W-1:0]         prev_xy;
  logic [C_scroll_div-1:0] div_cnt;
  logic [C_scroll_div-1:0] div_nxt_c;
  logic [C_y_bits-1:0]     offset;

  // A frame starts on the first cycle of (0,0); holding (0,0) does not retrigger.
  always_comb begin
    start_c   = ({x, y} == '0) && (prev_xy != '0);
    div_nxt_c = div_cnt;
    offset_c  = offset;
    if (start_c && !pause) begin
      div_nxt_c = div_cnt + 1'b1;
      if (div_nxt_c == '0) offset_c = offset + 1'b1;
    end
  end

  always_ff @(posedge clki or negedge resn) begin
    if (!resn) begin
      prev_xy     <= '1;
      frame_start <= 1'b0;
      frame_count <= '0;
      div_cnt     <= '0;
      offset      <= '0;
    end else begin
      prev_xy     <= {x, y};
      frame_start <= start_c;
      if (start_c) frame_count <= frame_count + 1'b1;
      div_cnt     <= div_nxt_c;
      offset      <= offset_c;
    end
  end

endmodule

// File: rtl/oled_pattern_gen.sv
// Animated RGB565 test-pattern source; returns the color of pixel (x,y) one
// cycle later, with mode and animation changing only at frame boundaries.
module oled_pattern_gen #(
  parameter int unsigned C_x_bits     = 7,
  parameter int unsigned C_y_bits     = 8,
  parameter int unsigned C_cell_log2  = 3,
  parameter logic [15:0] C_color_a    = 16'h07E0,
  parameter logic [15:0] C_color_b    = 16'hF800,
  parameter int unsigned C_scroll_div = 2
) (
  input logic               clki,
  input logic               resn,
  oled_pattern_gen_if.slave bus
);
  import oled_pkg::*;

  mode_e               mode_q;
  mode_e               mode_c;
  logic                start_c;
  logic [C_y_bits-1:0] offset_c;
  logic [C_x_bits-1:0] xs_c;
  logic [C_y_bits-1:0] ys_c;
  logic [RGB_W-1:0]    color_c;

  oled_frame_tracker #(
    .C_x_bits    (C_x_bits),
    .C_y_bits    (C_y_bits),
    .C_scroll_div(C_scroll_div)
  ) u_tracker (
    .clki       (clki),
    .resn       (resn),
    .x          (bus.x),
    .y          (bus.y),
    .pause      (bus.pause),
    .start_c    (start_c),
    .offset_c   (offset_c),
    .frame_start(bus.frame_start),
    .frame_count(bus.frame_count)
  );

  // On a frame-start cycle the new frame's mode and offset already apply.
  always_comb begin
    mode_c  = start_c ? mode_e'(bus.mode) : mode_q;
    xs_c    = bus.x + C_x_bits'(offset_c);
    ys_c    = bus.y + offset_c;
    color_c = '0;
    case (mode_c)
      MODE_CHECKER:
        color_c = (bus.x[C_cell_log2] ^ bus.y[C_cell_log2]) ? C_color_a : C_color_b;
      MODE_BARS:
        color_c = bar_color(3'(bus.x >> (C_x_bits - 3)));
      MODE_GRADIENT:
        color_c = rgb565(5'(bus.x >> (C_x_bits - 5)),
                         6'(bus.y >> (C_y_bits - 6)),
                         offset_c[4:0]);
      MODE_SCROLL:
        color_c = (xs_c[C_cell_log2] ^ ys_c[C_cell_log2]) ? C_color_a : C_color_b;
      default: color_c = '0;
    endcase
  end

  always_ff @(posedge clki or negedge resn) begin
    if (!resn) begin
      mode_q    <= MODE_CHECKER;
      bus.color <= '0;
    end else begin
      mode_q    <= mode_c;
      bus.color <= color_c;
    end
  end

endmodule
